ctrl_seq: RTL and testbench

- Parametrised, self-sequencing control unit for the SimpleCPU datapath.
- Owns its own phase FSM, replacing external t0..t7 beats, and decodes cmd internally.
- Drives one-hot register in/out enable vectors sized by NREG.
- Adds PUSH/POP, HALT, a memory ready handshake (variable-latency RAM) and an illegal-opcode flag.

---
 rtl/ctrl_seq_pkg.sv | 50 +++++
 rtl/ctrl_seq_dec.sv | 38 +++
 rtl/ctrl_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_ctrl_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the SimpleCPU control sequencer: opcodes, phase codes,
// instruction field positions and the register-index to one-hot helper.
package ctrl_seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_IFETCH = 3'd1,
        ST_DECODE = 3'd2,
        ST_E1     = 3'd3,
        ST_E2     = 3'd4,
        ST_E3     = 3'd5,
        ST_HALT   = 3'd7
    } state_e;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 11;
    localparam int DST_HI = 10;
    localparam int DST_LO = 8;
    localparam int SRC_HI = 2;
    localparam int SRC_LO = 0;

    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_LD   = 5'd1;
    localparam logic [4:0] OP_LN   = 5'd2;
    localparam logic [4:0] OP_CP   = 5'd3;
    localparam logic [4:0] OP_ST   = 5'd4;
    localparam logic [4:0] OP_SHL  = 5'd5;
    localparam logic [4:0] OP_ADD  = 5'd6;
    localparam logic [4:0] OP_SUB  = 5'd7;
    localparam logic [4:0] OP_JZ   = 5'd8;
    localparam logic [4:0] OP_JB   = 5'd9;
    localparam logic [4:0] OP_JMP  = 5'd10;
    localparam logic [4:0] OP_XOR  = 5'd11;
    localparam logic [4:0] OP_OR   = 5'd12;
    localparam logic [4:0] OP_AND  = 5'd13;
    localparam logic [4:0] OP_SHR  = 5'd14;
    localparam logic [4:0] OP_NOT  = 5'd15;
    localparam logic [4:0] OP_PUSH = 5'd16;
    localparam logic [4:0] OP_POP  = 5'd17;
    localparam logic [4:0] OP_HALT = 5'd18;

    // Index 0 (MAR) and indices beyond nreg map to no general-register bit.
    function automatic logic [7:0] reg_onehot(input logic [2:0] idx, input logic [2:0] nreg);
        logic [7:0] oh;
        oh = '0;
        if (idx != 3'd0 && idx <= nreg) oh = 8'd1 << (idx - 3'd1);
        return oh;
    endfunction

endpackage

// File: rtl/ctrl_seq_dec.sv
// Opcode classifier: groups opcodes by the execution shape they need and
// flags which register fields an instruction actually references.
module ctrl_seq_dec
    import ctrl_seq_pkg::*;
(
    input  logic [4:0] op_i,
    output logic       legal_o,
    output logic       is_nop_o,
    output logic       is_halt_o,
    output logic       is_alu_o,
    output logic       is_mem_o,
    output logic       is_jump_o,
    output logic       uses_e3_o,
    output logic       uses_dst_o,
    output logic       uses_src_o
);

    always_comb begin
        legal_o    = (op_i <= OP_HALT);
        is_nop_o   = (op_i == OP_NOP);
        is_halt_o  = (op_i == OP_HALT);
        is_alu_o   = 1'b0;
        is_mem_o   = (op_i == OP_LD) || (op_i == OP_ST);
        is_jump_o  = (op_i == OP_JZ) || (op_i == OP_JB) || (op_i == OP_JMP);
        uses_e3_o  = (op_i == OP_PUSH) || (op_i == OP_POP);
        uses_dst_o = 1'b0;
        uses_src_o = (op_i == OP_CP) || (op_i == OP_PUSH);
        case (op_i)
            OP_SHL, OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_SHR, OP_NOT: begin
                is_alu_o   = 1'b1;
                uses_dst_o = 1'b1;
            end
            OP_LD, OP_LN, OP_CP, OP_ST, OP_POP: uses_dst_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// Self-sequencing SimpleCPU control unit: phase FSM, IR capture and the
// per-phase bus enables, gated to zero while reset is held.
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int DW       = 16,
    parameter int NREG     = 4,
    parameter int SP_IDX   = 3,
    parameter int JB_LIMIT = 128
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DW-1:0]   cmd,
    input  logic [DW-1:0]   acc,
    input  logic            mem_rdy,
    output logic [NREG-1:0] idr,
    output logic [NREG-1:0] edr,
    output logic            iir,
    output logic            eir,
    output logic            imar,
    output logic            emar,
    output logic            ialu,
    output logic            ealu,
    output logic            iram,
    output logic            eram,
    output logic            iaddr,
    output logic            mem_req,
    output logic            pc_oe,
    output logic            pc_ld,
    output logic            pc_inc,
    output logic            sp_inc,
    output logic            sp_dec,
    output logic [3:0]      alu_op,
    output logic [2:0]      phase,
    output logic            halted,
    output logic            illegal
);

    localparam logic [2:0]    NREG_L = 3'(NREG);
    localparam logic [2:0]    SP_L   = 3'(SP_IDX);
    localparam logic [DW-1:0] JB_L   = DW'(JB_LIMIT);

    typedef struct packed {
        logic [NREG-1:0] idr;
        logic [NREG-1:0] edr;
        logic            iir, eir, imar, emar, ialu, ealu, iram, eram, iaddr;
        logic            mem_req, pc_oe, pc_ld, pc_inc, sp_inc, sp_dec, halted, illegal;
        logic [3:0]      alu_op;
    } ctl_t;

    state_e        state_q, state_d;
    logic [DW-1:0] ir_q, ir_d;
    ctl_t          ctl, ctl_g;

    logic [4:0] op;
    logic [2:0] dst, src;
    logic [7:0] dst_oh8, src_oh8, sp_oh8;
    logic [NREG-1:0] dst_oh, src_oh, sp_oh;
    logic legal, is_nop, is_halt, is_alu, is_mem, is_jump, uses_e3, uses_dst, uses_src;
    logic reg_bad, taken;
    logic unused_bits;

    assign op      = ir_q[OP_HI:OP_LO];
    assign dst     = ir_q[DST_HI:DST_LO];
    assign src     = ir_q[SRC_HI:SRC_LO];
    assign dst_oh8 = reg_onehot(dst, NREG_L);
    assign src_oh8 = reg_onehot(src, NREG_L);
    assign sp_oh8  = reg_onehot(SP_L, NREG_L);
    assign dst_oh  = dst_oh8[NREG-1:0];
    assign src_oh  = src_oh8[NREG-1:0];
    assign sp_oh   = sp_oh8[NREG-1:0];
    assign unused_bits = ^{ir_q, dst_oh8, src_oh8, sp_oh8};

    ctrl_seq_dec u_dec (
        .op_i       (op),
        .legal_o    (legal),
        .is_nop_o   (is_nop),
        .is_halt_o  (is_halt),
        .is_alu_o   (is_alu),
        .is_mem_o   (is_mem),
        .is_jump_o  (is_jump),
        .uses_e3_o  (uses_e3),
        .uses_dst_o (uses_dst),
        .uses_src_o (uses_src)
    );

    assign reg_bad = (uses_dst && dst > NREG_L) || (uses_src && src > NREG_L);
    assign taken   = is_jump && ((op == OP_JMP) ||
                                 (op == OP_JZ && acc == '0) ||
                                 (op == OP_JB && acc >= JB_L));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        ctl     = '0;
        case (state_q)
            ST_FETCH: begin
                ctl.pc_oe = 1'b1;
                ctl.iaddr = 1'b1;
                state_d   = ST_IFETCH;
            end
            ST_IFETCH: begin
                ctl.mem_req = 1'b1;
                ctl.eram    = 1'b1;
                ctl.iir     = 1'b1;
                if (mem_rdy) begin
                    ctl.pc_inc = 1'b1;
                    ir_d       = cmd;
                    state_d    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ctl.eir     = 1'b1;
                ctl.imar    = 1'b1;
                ctl.illegal = !legal || reg_bad;
                if (!legal || is_nop) state_d = ST_FETCH;
                else if (is_halt)     state_d = ST_HALT;
                else                  state_d = ST_E1;
            end
            ST_E1: begin
                state_d = (is_alu || is_mem || uses_e3) ? ST_E2 : ST_FETCH;
                if (is_alu) begin
                    ctl.emar   = (dst == 3'd0);
                    ctl.edr    = dst_oh;
                    ctl.ialu   = 1'b1;
                    ctl.alu_op = op[3:0];
                end else if (op == OP_LN) begin
                    ctl.emar = 1'b1;
                    ctl.imar = (dst == 3'd0);
                    ctl.idr  = dst_oh;
                end else if (op == OP_CP && src != dst) begin
                    // Copying a register onto itself drives nothing, so idr/edr never collide.
                    ctl.emar = (src == 3'd0);
                    ctl.edr  = src_oh;
                    ctl.imar = (dst == 3'd0);
                    ctl.idr  = dst_oh;
                end else if (is_mem) begin
                    ctl.emar  = 1'b1;
                    ctl.iaddr = 1'b1;
                end else if (taken) begin
                    ctl.emar  = 1'b1;
                    ctl.pc_ld = 1'b1;
                end else if (op == OP_PUSH) begin
                    ctl.sp_dec = 1'b1;
                end else if (op == OP_POP) begin
                    ctl.edr   = sp_oh;
                    ctl.iaddr = 1'b1;
                end
            end
            ST_E2: begin
                state_d = ST_FETCH;
                if (is_alu) begin
                    ctl.ealu = 1'b1;
                    ctl.idr  = NREG'(1);
                end else if (op == OP_ST) begin
                    ctl.emar    = (dst == 3'd0);
                    ctl.edr     = dst_oh;
                    ctl.iram    = 1'b1;
                    ctl.mem_req = 1'b1;
                    if (!mem_rdy) state_d = ST_E2;
                end else if (op == OP_LD || op == OP_POP) begin
                    ctl.eram    = 1'b1;
                    ctl.imar    = (dst == 3'd0);
                    ctl.idr     = dst_oh;
                    ctl.mem_req = 1'b1;
                    if (!mem_rdy)     state_d = ST_E2;
                    else if (uses_e3) state_d = ST_E3;
                end else if (op == OP_PUSH) begin
                    ctl.edr   = sp_oh;
                    ctl.iaddr = 1'b1;
                    state_d   = ST_E3;
                end
            end
            ST_E3: begin
                state_d = ST_FETCH;
                if (op == OP_PUSH) begin
                    ctl.emar    = (src == 3'd0);
                    ctl.edr     = src_oh;
                    ctl.iram    = 1'b1;
                    ctl.mem_req = 1'b1;
                    if (!mem_rdy) state_d = ST_E3;
                end else if (op == OP_POP) begin
                    ctl.sp_inc = 1'b1;
                end
            end
            ST_HALT: begin
                ctl.halted = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Enables drop the moment reset asserts, independent of the clock.
    assign ctl_g = reset ? ctl : '0;

    assign idr     = ctl_g.idr;
    assign edr     = ctl_g.edr;
    assign iir     = ctl_g.iir;
    assign eir     = ctl_g.eir;
    assign imar    = ctl_g.imar;
    assign emar    = ctl_g.emar;
    assign ialu    = ctl_g.ialu;
    assign ealu    = ctl_g.ealu;
    assign iram    = ctl_g.iram;
    assign eram    = ctl_g.eram;
    assign iaddr   = ctl_g.iaddr;
    assign mem_req = ctl_g.mem_req;
    assign pc_oe   = ctl_g.pc_oe;
    assign pc_ld   = ctl_g.pc_ld;
    assign pc_inc  = ctl_g.pc_inc;
    assign sp_inc  = ctl_g.sp_inc;
    assign sp_dec  = ctl_g.sp_dec;
    assign alu_op  = ctl_g.alu_op;
    assign halted  = ctl_g.halted;
    assign illegal = ctl_g.illegal;
    assign phase   = state_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: per-instruction cycle scripts built from the instruction
// set description, driven with random operands, waits and don't-care inputs.
module tb_ctrl_seq;

    localparam int DW = 16, NREG = 4, SP_IDX = 3, JB_LIMIT = 128;

    localparam int B_IIR = 1 << 16, B_EIR = 1 << 15, B_IMAR = 1 << 14, B_EMAR = 1 << 13;
    localparam int B_IALU = 1 << 12, B_EALU = 1 << 11, B_IRAM = 1 << 10, B_ERAM = 1 << 9;
    localparam int B_IADDR = 1 << 8, B_MREQ = 1 << 7, B_PCOE = 1 << 6, B_PCLD = 1 << 5;
    localparam int B_PCINC = 1 << 4, B_SPINC = 1 << 3, B_SPDEC = 1 << 2, B_HALT = 1 << 1;
    localparam int B_ILL = 1;

    logic clk, reset, mem_rdy;
    logic [DW-1:0] cmd, acc;
    logic [NREG-1:0] idr, edr;
    logic iir, eir, imar, emar, ialu, ealu, iram, eram, iaddr, mem_req;
    logic pc_oe, pc_ld, pc_inc, sp_inc, sp_dec, halted, illegal;
    logic [3:0] alu_op;
    logic [2:0] phase;
    logic [16:0] misc_obs;

    ctrl_seq #(.DW(DW), .NREG(NREG), .SP_IDX(SP_IDX), .JB_LIMIT(JB_LIMIT)) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .acc(acc), .mem_rdy(mem_rdy),
        .idr(idr), .edr(edr), .iir(iir), .eir(eir), .imar(imar), .emar(emar),
        .ialu(ialu), .ealu(ealu), .iram(iram), .eram(eram), .iaddr(iaddr),
        .mem_req(mem_req), .pc_oe(pc_oe), .pc_ld(pc_ld), .pc_inc(pc_inc),
        .sp_inc(sp_inc), .sp_dec(sp_dec), .alu_op(alu_op), .phase(phase),
        .halted(halted), .illegal(illegal)
    );

    assign misc_obs = {iir, eir, imar, emar, ialu, ealu, iram, eram, iaddr,
                       mem_req, pc_oe, pc_ld, pc_inc, sp_inc, sp_dec, halted, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int ph;
        int idr;
        int edr;
        int misc;
        int alu;
        bit mrdy;
        bit cap;
    } step_t;

    step_t q[$];

    function automatic int oh(int n);
        return (n >= 1 && n <= NREG) ? (1 << (n - 1)) : 0;
    endfunction

    function automatic step_t mk(int ph, int ie, int ee, int misc, int alu);
        step_t s;
        s.ph = ph; s.idr = ie; s.edr = ee; s.misc = misc; s.alu = alu;
        s.mrdy = 1'($urandom_range(0, 1));
        s.cap = 1'b0;
        return s;
    endfunction

    task automatic push_mem(input step_t s, input int w, input int extra, input bit cap);
        step_t t;
        for (int i = 0; i < w; i++) begin
            t = s; t.mrdy = 1'b0; q.push_back(t);
        end
        t = s; t.mrdy = 1'b1; t.misc = t.misc | extra; t.cap = cap;
        q.push_back(t);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, from FETCH to its last step.
    task automatic build(input logic [15:0] ins, input logic [15:0] a, input int wif, input int wmem);
        int op, d, s, dmar, smar;
        bit legal, usesd, usess, bad, alu;
        op = int'(ins[15:11]); d = int'(ins[10:8]); s = int'(ins[2:0]);
        dmar = (d == 0); smar = (s == 0);
        legal = (op <= 18);
        usesd = (op >= 1 && op <= 7) || (op >= 11 && op <= 15) || op == 17;
        usess = (op == 3) || (op == 16);
        bad   = (usesd && d > NREG) || (usess && s > NREG);
        alu   = (op >= 5 && op <= 7) || (op >= 11 && op <= 15);
        q.delete();
        q.push_back(mk(0, 0, 0, B_PCOE | B_IADDR, 0));
        push_mem(mk(1, 0, 0, B_MREQ | B_ERAM | B_IIR, 0), wif, B_PCINC, 1'b1);
        q.push_back(mk(2, 0, 0, B_EIR | B_IMAR | ((!legal || bad) ? B_ILL : 0), 0));
        if (!legal || op == 0) return;
        if (op == 18) begin
            q.push_back(mk(7, 0, 0, B_HALT, 0));
            return;
        end
        if (alu) begin
            q.push_back(mk(3, 0, oh(d), (dmar ? B_EMAR : 0) | B_IALU, op % 16));
            q.push_back(mk(4, 1, 0, B_EALU, 0));
        end else begin
            case (op)
                2: q.push_back(mk(3, oh(d), 0, B_EMAR | (dmar ? B_IMAR : 0), 0));
                3: if (s == d) q.push_back(mk(3, 0, 0, 0, 0));
                   else q.push_back(mk(3, oh(d), oh(s), (smar ? B_EMAR : 0) | (dmar ? B_IMAR : 0), 0));
                4: begin
                    q.push_back(mk(3, 0, 0, B_EMAR | B_IADDR, 0));
                    push_mem(mk(4, 0, oh(d), (dmar ? B_EMAR : 0) | B_IRAM | B_MREQ, 0), wmem, 0, 1'b0);
                end
                1: begin
                    q.push_back(mk(3, 0, 0, B_EMAR | B_IADDR, 0));
                    push_mem(mk(4, oh(d), 0, (dmar ? B_IMAR : 0) | B_ERAM | B_MREQ, 0), wmem, 0, 1'b0);
                end
                8, 9, 10: begin
                    bit tk;
                    tk = (op == 10) || (op == 8 && a == 0) || (op == 9 && int'(a) >= JB_LIMIT);
                    q.push_back(mk(3, 0, 0, tk ? (B_EMAR | B_PCLD) : 0, 0));
                end
                16: begin
                    q.push_back(mk(3, 0, 0, B_SPDEC, 0));
                    q.push_back(mk(4, 0, oh(SP_IDX), B_IADDR, 0));
                    push_mem(mk(5, 0, oh(s), (smar ? B_EMAR : 0) | B_IRAM | B_MREQ, 0), wmem, 0, 1'b0);
                end
                17: begin
                    q.push_back(mk(3, 0, oh(SP_IDX), B_IADDR, 0));
                    push_mem(mk(4, oh(d), 0, (dmar ? B_IMAR : 0) | B_ERAM | B_MREQ, 0), wmem, 0, 1'b0);
                    q.push_back(mk(5, 0, 0, B_SPINC, 0));
                end
                default: ;
            endcase
        end
    endtask

    task automatic drive_check(input step_t s, input logic [15:0] ins, input logic [15:0] a);
        @(negedge clk);
        mem_rdy = s.mrdy;
        acc     = a;
        cmd     = s.cap ? ins : 16'($urandom);
        #1;
        check($sformatf("phase[%04h]", ins), 32'(phase), s.ph);
        check($sformatf("idr[%04h]", ins), 32'(idr), s.idr);
        check($sformatf("edr[%04h]", ins), 32'(edr), s.edr);
        check($sformatf("ctl[%04h]", ins), 32'(misc_obs), s.misc);
        check($sformatf("alu_op[%04h]", ins), 32'(alu_op), s.alu);
        check("idr_edr_overlap", 32'(idr & edr), 0);
        check("idr_multi", 32'($countones(idr) > 1), 0);
        check("edr_multi", 32'($countones(edr) > 1), 0);
    endtask

    task automatic run_instr(input logic [15:0] ins, input logic [15:0] a, input int wif, input int wmem);
        build(ins, a, wif, wmem);
        foreach (q[i]) drive_check(q[i], ins, a);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_phase"}, 32'(phase), 0);
        check({tag, "_idr"}, 32'(idr), 0);
        check({tag, "_edr"}, 32'(edr), 0);
        check({tag, "_ctl"}, 32'(misc_obs), 0);
        check({tag, "_alu"}, 32'(alu_op), 0);
    endtask

    function automatic logic [15:0] enc(int op, int d, int s);
        return {5'(op), 3'(d), 5'd0, 3'(s)};
    endfunction

    initial begin
        logic [15:0] ins, a;
        int op;
        reset = 1'b0; mem_rdy = 1'b1; cmd = '0; acc = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_rdy = 1'($urandom_range(0, 1));
            cmd = 16'($urandom);
            #1 check_reset_outputs("reset");
        end
        @(posedge clk); #2 reset = 1'b1;

        run_instr(16'h1100, 16'h0000, 0, 0);
        run_instr(16'h3200, 16'h1234, 0, 0);
        run_instr(enc(1, 4, 0), 16'h0000, 0, 3);
        run_instr(enc(8, 0, 0), 16'd0, 0, 0);
        run_instr(enc(8, 0, 0), 16'd5, 0, 0);
        run_instr(enc(9, 0, 0), 16'd128, 0, 0);
        run_instr(enc(9, 0, 0), 16'd127, 0, 0);
        run_instr(enc(10, 0, 0), 16'hffff, 1, 0);
        run_instr(enc(16, 0, 1), 16'h0000, 0, 0);
        run_instr(enc(17, 4, 0), 16'h0000, 0, 2);
        run_instr(enc(25, 1, 1), 16'h0000, 2, 0);
        run_instr(enc(6, 6, 0), 16'h0000, 0, 0);
        run_instr(enc(3, 2, 2), 16'h0000, 0, 0);

        for (int n = 0; n < 250; n++) begin
            op = $urandom_range(0, 31);
            if (op == 18) op = 0;
            ins = {5'(op), 3'($urandom_range(0, 7)), 5'($urandom), 3'($urandom_range(0, 7))};
            case ($urandom_range(0, 3))
                0: a = 16'd0;
                1: a = 16'd127;
                2: a = 16'd128;
                default: a = 16'($urandom);
            endcase
            run_instr(ins, a, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Reset dropped while LD waits on memory in E2.
        build(enc(1, 2, 0), 16'h0000, 0, 3);
        for (int i = 0; i < 5; i++) drive_check(q[i], enc(1, 2, 0), 16'h0000);
        #2 reset = 1'b0;
        #1 check_reset_outputs("midreset");
        @(posedge clk); #2 reset = 1'b1;
        run_instr(enc(2, 3, 0), 16'h0000, 0, 0);

        run_instr(enc(18, 0, 0), 16'h0000, 0, 0);
        for (int i = 0; i < 6; i++) drive_check(mk(7, 0, 0, B_HALT, 0), 16'hdead, 16'h0000);
        #2 reset = 1'b0;
        #1 check_reset_outputs("haltreset");
        @(posedge clk); #2 reset = 1'b1;
        run_instr(enc(0, 0, 0), 16'h0000, 0, 0);
        run_instr(16'h1100, 16'h0000, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
